// File: rtl/boot_pkg.sv
// Shared definitions for the ICCM boot loader: FSM states and the length-field width.
package boot_pkg;

    localparam int unsigned LenW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StWrite,
        StDone,
        StErr
    } boot_state_e;

endpackage

// File: rtl/iccm_boot_loader.sv
// Receives a length-prefixed image byte stream from UART RX and writes it word-wise into ICCM,
// holding the core in reset until the image is complete.
module iccm_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned SramAw        = 12,
    parameter int unsigned TimeoutCycles = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic              iccm_req_o,
    output logic              iccm_we_o,
    output logic [SramAw-1:0] iccm_addr_o,
    output logic [31:0]       iccm_wdata_o,
    output logic              hold_core_o,
    output logic              boot_done_o,
    output logic              err_o
);

    localparam int unsigned TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles - 1);

    boot_state_e       r_state, w_state_nxt;
    logic [LenW-1:0]   r_count, w_count_nxt;
    logic [SramAw:0]   r_widx, w_widx_nxt;
    logic [1:0]        r_bidx, w_bidx_nxt;
    logic [31:0]       r_data, w_data_nxt;
    logic [TimerW-1:0] r_timer, w_timer_nxt;

    logic [TimerW-1:0] w_timer_inc;
    logic              w_timeout;
    logic [LenW-1:0]   w_len;
    logic [SramAw:0]   w_widx_inc;
    logic              w_len_too_big;

    assign w_timer_inc = r_timer + TimerW'(1);
    // Expire on the edge at which the idle counter would reach TimeoutCycles-1.
    assign w_timeout   = (w_timer_inc == TimerMax);
    assign w_len       = {rx_byte_i, r_count[7:0]};
    assign w_widx_inc  = r_widx + (SramAw + 1)'(1);
    assign w_len_too_big = 64'(w_len) > (64'd1 << SramAw);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_widx_nxt  = r_widx;
        w_bidx_nxt  = r_bidx;
        w_data_nxt  = r_data;
        w_timer_nxt = r_timer;
        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    w_state_nxt = StLen0;
                    w_count_nxt = '0;
                    w_widx_nxt  = '0;
                    w_bidx_nxt  = '0;
                    w_data_nxt  = '0;
                    w_timer_nxt = '0;
                end
            end
            StLen0: begin
                if (rx_valid_i) begin
                    w_count_nxt[7:0] = rx_byte_i;
                    w_timer_nxt      = '0;
                    w_state_nxt      = StLen1;
                end else if (w_timeout) begin
                    w_state_nxt = StErr;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            StLen1: begin
                if (rx_valid_i) begin
                    w_count_nxt = w_len;
                    w_timer_nxt = '0;
                    w_widx_nxt  = '0;
                    w_bidx_nxt  = '0;
                    w_data_nxt  = '0;
                    if (w_len == '0) begin
                        w_state_nxt = StDone;
                    end else if (w_len_too_big) begin
                        w_state_nxt = StErr;
                    end else begin
                        w_state_nxt = StData;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = StErr;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            StData: begin
                if (rx_valid_i) begin
                    w_data_nxt[{r_bidx, 3'b000} +: 8] = rx_byte_i;
                    w_bidx_nxt  = r_bidx + 2'd1;
                    w_timer_nxt = '0;
                    if (r_bidx == 2'd3) begin
                        w_state_nxt = StWrite;
                    end
                end else if (w_timeout) begin
                    // Any partially packed word is simply abandoned.
                    w_state_nxt = StErr;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            StWrite: begin
                w_widx_nxt  = w_widx_inc;
                w_bidx_nxt  = '0;
                w_timer_nxt = '0;
                if (32'(w_widx_inc) == 32'(r_count)) begin
                    w_state_nxt = StDone;
                end else begin
                    w_state_nxt = StData;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_count <= '0;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_data  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_widx  <= w_widx_nxt;
            r_bidx  <= w_bidx_nxt;
            r_data  <= w_data_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    assign iccm_req_o   = (r_state == StWrite);
    assign iccm_we_o    = iccm_req_o;
    assign iccm_addr_o  = iccm_req_o ? r_widx[SramAw-1:0] : '0;
    assign iccm_wdata_o = iccm_req_o ? r_data : '0;
    assign hold_core_o  = (r_state != StDone);
    assign boot_done_o  = (r_state == StDone);
    assign err_o        = (r_state == StErr);

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Self-checking bench: transaction-level reference model compared every cycle, plus directed
// literal checks and randomized loads.
module tb_iccm_boot_loader;

    localparam int unsigned AW  = 12;
    localparam int unsigned TO  = 16;
    localparam int          MAX = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic          iccm_req, iccm_we, hold_core, boot_done, err;
    logic [AW-1:0] iccm_addr;
    logic [31:0]   iccm_wdata;

    iccm_boot_loader #(
        .SramAw       (AW),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .rx_byte_i   (rx_byte),
        .rx_valid_i  (rx_valid),
        .iccm_req_o  (iccm_req),
        .iccm_we_o   (iccm_we),
        .iccm_addr_o (iccm_addr),
        .iccm_wdata_o(iccm_wdata),
        .hold_core_o (hold_core),
        .boot_done_o (boot_done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_drive_cyc = 0;

    // Reference model: a load is "active" from start until done/err; bytes are collected in a
    // queue, each completed 4-byte word costs one extra write cycle during which RX is deaf.
    int         m_mode = 0;  // 0 idle, 1 loading, 2 done, 3 error
    int         m_n = 0;     // bytes accepted in this load (2 length + data)
    int         m_len = 0;
    int         m_silent = 0;
    int         m_words = 0;
    bit         m_wr = 1'b0;
    logic [7:0] m_q[$];

    int          wl_addr[$];
    logic [31:0] wl_data[$];
    int          wl_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_mode = 0; m_n = 0; m_len = 0; m_silent = 0; m_words = 0; m_wr = 1'b0;
            m_q.delete();
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_n = 0; m_len = 0; m_silent = 0; m_words = 0; m_wr = 1'b0;
                m_q.delete();
            end
        end else if (m_wr) begin
            m_wr = 1'b0;
            m_words++;
            m_silent = 0;
            if (m_words == m_len) m_mode = 2;
        end else if (rx_valid) begin
            m_q.push_back(rx_byte);
            m_n++;
            m_silent = 0;
            if (m_n == 2) begin
                m_len = int'({rx_byte, m_q[0]});
                if (m_len == 0) m_mode = 2;
                else if (m_len > MAX) m_mode = 3;
            end else if (m_n > 2 && (m_n - 2) % 4 == 0) begin
                m_wr = 1'b1;
            end
        end else if (m_silent + 1 == TO - 1) begin
            m_mode = 3;
        end else begin
            m_silent++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_cycle();
        logic [31:0] e_data;
        int          e_addr;
        e_data = 32'h0;
        e_addr = 0;
        if (m_wr) begin
            e_data = {m_q[m_n-1], m_q[m_n-2], m_q[m_n-3], m_q[m_n-4]};
            e_addr = m_words;
        end
        chk("req", 32'(iccm_req), 32'(m_wr));
        chk("we", 32'(iccm_we), 32'(m_wr));
        chk("addr", 32'(iccm_addr), 32'(e_addr));
        chk("wdata", iccm_wdata, e_data);
        chk("hold", 32'(hold_core), 32'(m_mode != 2));
        chk("done", 32'(boot_done), 32'(m_mode == 2));
        chk("err", 32'(err), 32'(m_mode == 3));
        if (iccm_req === 1'b1) begin
            wl_addr.push_back(int'(iccm_addr));
            wl_data.push_back(iccm_wdata);
            wl_cyc.push_back(cyc);
        end
    endtask

    // One clock: compare at the falling edge, then drive inputs for the next rising edge.
    task automatic step(input bit r, input bit s, input bit v, input logic [7:0] b);
        @(negedge clk);
        compare_cycle();
        #2;
        rst = r; start = s; rx_valid = v; rx_byte = b;
        if (v) last_drive_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
        idle(1);
    endtask

    initial begin
        int base, c_w0, c_w1, c_err, nbytes, gap;
        logic [31:0] w, last_w;
        #1 rst = 1'b1;
        idle(3);
        chk("reset_hold", 32'(hold_core), 32'd1);
        chk("reset_outs", {28'(iccm_addr), 1'b0, iccm_req, boot_done, err}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        idle(2);

        // Two-word image.
        base = wl_addr.size();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send(8'h02); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE); c_w0 = last_drive_cyc; idle(1);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12); c_w1 = last_drive_cyc; idle(2);
        chk("img_nwrites", 32'(wl_addr.size() - base), 32'd2);
        if (wl_addr.size() - base == 2) begin
            chk("img_addr0", 32'(wl_addr[base]), 32'd0);
            chk("img_data0", wl_data[base], 32'hDEADBEEF);
            chk("img_lat0", 32'(wl_cyc[base] - c_w0), 32'd1);
            chk("img_addr1", 32'(wl_addr[base+1]), 32'd1);
            chk("img_data1", wl_data[base+1], 32'h12345678);
            chk("img_lat1", 32'(wl_cyc[base+1] - c_w1), 32'd1);
        end
        chk("img_done", 32'(boot_done), 32'd1);
        chk("img_hold", 32'(hold_core), 32'd0);

        // Zero-length image.
        base = wl_addr.size();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send(8'h00); send(8'h00);
        chk("zero_done", 32'(boot_done), 32'd1);
        idle(2);
        chk("zero_nwrites", 32'(wl_addr.size() - base), 32'd0);

        // Oversize length 4097, then restart.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send(8'h01); send(8'h10);
        chk("big_err", 32'(err), 32'd1);
        chk("big_hold", 32'(hold_core), 32'd1);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("restart_err", 32'(err), 32'd0);
        chk("restart_hold", 32'(hold_core), 32'd1);

        // Timeout after two data bytes (already in LEN0).
        base = wl_addr.size();
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        c_err = -1;
        for (int i = 0; i < 40 && c_err < 0; i++) begin
            idle(1);
            if (err === 1'b1) c_err = cyc;
        end
        chk("to_fired", 32'(c_err >= 0), 32'd1);
        if (c_err >= 0) chk("to_latency", 32'(c_err - last_drive_cyc), 32'd16);
        chk("to_nwrites", 32'(wl_addr.size() - base), 32'd0);

        // Reset between bytes 2 and 3 of a word.
        base = wl_addr.size();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_hold", 32'(hold_core), 32'd1);
        chk("rst_outs", {iccm_wdata[27:0], iccm_req, iccm_we, boot_done, err}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h33);
        send(8'h44); idle(3);
        chk("rst_nwrites", 32'(wl_addr.size() - base), 32'd0);
        chk("rst_idle_done", 32'(boot_done), 32'd0);

        // Randomized loads: short images, oversize lengths, stray starts, long gaps.
        for (int l = 0; l < 30; l++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            w = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                w[15:0] = 16'(MAX + 1 + $urandom_range(0, 1000));
            end else begin
                w[15:0] = 16'($urandom_range(0, 6));
            end
            nbytes = 2 + 4 * int'(w[15:0] > 16'(MAX) ? 16'd1 : w[15:0]);
            if ($urandom_range(0, 5) == 0) nbytes = $urandom_range(1, nbytes);
            for (int i = 0; i < nbytes; i++) begin
                gap = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 2);
                idle(gap);
                step(1'b0, ($urandom_range(0, 9) == 0), 1'b1,
                     (i < 2) ? w[8*i +: 8] : 8'($urandom));
            end
            for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            idle(20);
        end

        // Full 4096-word image, with one byte landing exactly on the timeout edge.
        base = wl_addr.size();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        send(8'h00); send(8'h10);
        last_w = 32'h0;
        for (int k = 0; k < MAX; k++) begin
            if (k == 10) idle(14);
            last_w = $urandom;
            send_word(last_w);
        end
        idle(2);
        chk("full_nwrites", 32'(wl_addr.size() - base), 32'(MAX));
        if (wl_addr.size() > 0) begin
            chk("full_last_addr", 32'(wl_addr[wl_addr.size()-1]), 32'hFFF);
            chk("full_last_data", wl_data[wl_data.size()-1], last_w);
        end
        chk("full_done", 32'(boot_done), 32'd1);
        chk("full_err", 32'(err), 32'd0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
